// File: rtl/axi_rd_arb_pkg.sv
// Shared types and constants for the AXI read arbiter.
// State encoding and fixed AR burst attributes.
package axi_rd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'd1;
  localparam logic [2:0] AXI_SIZE_4B    = 3'd2;
  localparam int         LEN_W          = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or
// after ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  output logic            grant_valid,
  output logic [2:0]      grant_idx
);

  logic [3:0] cand;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 3'd0;
    cand        = 4'd0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr} + 4'(i);
      if (cand >= 4'(NREQ)) cand = cand - 4'(NREQ);
      for (int j = 0; j < NREQ; j++) begin
        if (!grant_valid && cand == 4'(j) && req[j]) begin
          grant_valid = 1'b1;
          grant_idx   = 3'(j);
        end
      end
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI4 read port among NREQ kernels; round-robin
// grant held for a whole burst, R beats steered to the owner.
module axi_read_arbiter
  import axi_rd_arb_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ*ADDR_W-1:0] req_araddr,
  input  logic [NREQ*8-1:0]      req_arlen,
  input  logic [NREQ-1:0]        req_arvalid,
  output logic [NREQ-1:0]        req_arready,
  output logic [DATA_W-1:0]      req_rdata,
  output logic [NREQ-1:0]        req_rvalid,
  input  logic [NREQ-1:0]        req_rready,
  output logic [ADDR_W-1:0]      s_axi_araddr,
  output logic [7:0]             s_axi_arlen,
  output logic [1:0]             s_axi_arburst,
  output logic [2:0]             s_axi_arsize,
  output logic                   s_axi_arvalid,
  input  logic                   s_axi_arready,
  input  logic [DATA_W-1:0]      s_axi_rdata,
  input  logic                   s_axi_rvalid,
  output logic                   s_axi_rready,
  output logic [2:0]             grant_id,
  output logic                   busy
);

  state_e             state_q, state_d;
  logic [2:0]         rr_ptr_q, rr_ptr_d;
  logic [2:0]         grant_q, grant_d;
  logic [LEN_W:0]     beats_q, beats_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   len_q, len_d;

  logic               grant_valid;
  logic [2:0]         grant_idx;
  logic [ADDR_W-1:0]  sel_addr;
  logic [LEN_W-1:0]   sel_len;
  logic               sel_rready;
  logic               r_hs;
  logic [2:0]         ptr_next;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req         (req_arvalid),
    .ptr         (rr_ptr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Candidate fields from the arbiter pick; steering from the held grant.
  always_comb begin
    sel_addr    = '0;
    sel_len     = '0;
    sel_rready  = 1'b0;
    req_arready = '0;
    req_rvalid  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == 3'(i)) begin
        sel_addr = req_araddr[i*ADDR_W +: ADDR_W];
        sel_len  = req_arlen[i*8 +: 8];
      end
      if (grant_q == 3'(i)) begin
        sel_rready     = req_rready[i];
        req_arready[i] = (state_q == ADDR) && s_axi_arready;
        req_rvalid[i]  = (state_q == DATA) && s_axi_rvalid;
      end
    end
  end

  assign r_hs     = (state_q == DATA) && s_axi_rvalid && sel_rready;
  assign ptr_next = (grant_q == 3'(NREQ-1)) ? 3'd0 : grant_q + 3'd1;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    beats_d  = beats_q;
    addr_d   = addr_q;
    len_d    = len_q;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          grant_d = grant_idx;
          addr_d  = sel_addr;
          len_d   = sel_len;
          beats_d = {1'b0, sel_len} + 9'd1;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (s_axi_arready) state_d = DATA;
      end
      DATA: begin
        if (r_hs) begin
          beats_d = beats_q - 9'd1;
          if (beats_q == 9'd1) begin
            state_d  = IDLE;
            rr_ptr_d = ptr_next;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= 3'd0;
      grant_q  <= 3'd0;
      beats_q  <= '0;
      addr_q   <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      beats_q  <= beats_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
    end
  end

  assign s_axi_araddr  = addr_q;
  assign s_axi_arlen   = len_q;
  assign s_axi_arburst = AXI_BURST_INCR;
  assign s_axi_arsize  = AXI_SIZE_4B;
  assign s_axi_arvalid = (state_q == ADDR);
  assign s_axi_rready  = (state_q == DATA) && sel_rready;
  assign req_rdata     = s_axi_rdata;
  assign grant_id      = grant_q;
  assign busy          = (state_q != IDLE);

endmodule
